ir_scan_sched: RTL

Scheduler that owns the shared SPI A2D interface on behalf of the six IR line sensors of the Follower. It sequences the inner, middle and outer emitter pairs. For each pair it turns on the emitter, waits a settle time, then issues two A2D conversions (left channel, then right). It publishes a coherent six-sample result set at the end of every full scan. It sits between the A2D interface block and the steering/PID logic, and is the only requester of the A2D.

---
 rtl/ir_scan_pkg.sv | 19 +
 rtl/ir_scan_sched_if.sv | 9 +
 rtl/ir_scan_timer.sv | 21 ++
 rtl/ir_scan_sched.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ir_scan_pkg.sv
// ir_scan_pkg: shared types and the fixed A2D channel map for the IR line-sensor scheduler.
package ir_scan_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R, NEXT} state_t;
    typedef enum logic [1:0] {IN, MID, OUT} pair_t;

    localparam logic [2:0] CH_IN_L  = 3'd1;
    localparam logic [2:0] CH_IN_R  = 3'd0;
    localparam logic [2:0] CH_MID_L = 3'd4;
    localparam logic [2:0] CH_MID_R = 3'd2;
    localparam logic [2:0] CH_OUT_L = 3'd3;
    localparam logic [2:0] CH_OUT_R = 3'd7;

    function automatic logic [2:0] pair_chnnl(pair_t p, logic rht);
        return rht ? (p == IN ? CH_IN_R : p == MID ? CH_MID_R : CH_OUT_R)
                   : (p == IN ? CH_IN_L : p == MID ? CH_MID_L : CH_OUT_L);
    endfunction

endpackage

// File: rtl/ir_scan_sched_if.sv
// ir_scan_sched_if: conversion handshake between the scheduler (master) and the A2D interface (slave).
interface ir_scan_sched_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    modport master (output strt_cnv, chnnl, input cnv_cmplt, res);
    modport slave  (input strt_cnv, chnnl, output cnv_cmplt, res);
endinterface

// File: rtl/ir_scan_timer.sv
// ir_scan_timer: loadable down-counter shared by the settle wait and the conversion timeout.
module ir_scan_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    assign zero = cnt_q == '0;

    always_comb cnt_d = load ? load_val : (en && !zero) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/ir_scan_sched.sv
// ir_scan_sched: sequences the three IR emitter pairs, runs two A2D conversions per pair,
// and publishes a coherent six-sample set once per full scan.
module ir_scan_sched import ir_scan_pkg::*; #(
    parameter int SETTLE_CYC = 4096,
    parameter int TMO_CYC    = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   scan_en,
    ir_scan_sched_if.master        a2d,
    output logic                   IR_in_en,
    output logic                   IR_mid_en,
    output logic                   IR_out_en,
    output logic [11:0]            lft_in,
    output logic [11:0]            rht_in,
    output logic [11:0]            lft_mid,
    output logic [11:0]            rht_mid,
    output logic [11:0]            lft_out,
    output logic [11:0]            rht_out,
    output logic                   scan_done,
    output logic                   tmo_err
);
    localparam int TW = $clog2(SETTLE_CYC > TMO_CYC ? SETTLE_CYC : TMO_CYC);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LD    = TW'(TMO_CYC - 1);

    state_t      state_q, state_d;
    pair_t       pair_q, pair_d;
    logic [2:0]  en_q, en_d;
    logic [11:0] sh_q [6];
    logic [11:0] sh_d [6];
    logic [11:0] out_q [6];
    logic [11:0] out_d [6];
    logic        tmo_err_q, tmo_err_d;
    logic        tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0] tmr_val;
    logic        waiting, hit, rht;
    logic [2:0]  idx;

    ir_scan_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign tmr_en  = state_q inside {SETTLE, WAIT_L, WAIT_R};
    assign waiting = state_q inside {WAIT_L, WAIT_R};
    // A completion on the timeout cycle still counts as a real result.
    assign hit     = waiting && (a2d.cnv_cmplt || tmr_zero);
    assign rht     = state_q inside {CNV_R, WAIT_R};
    assign idx     = {pair_q, rht};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= IDLE;
            pair_q    <= IN;
            en_q      <= '0;
            sh_q      <= '{default: '0};
            out_q     <= '{default: '0};
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pair_q    <= pair_d;
            en_q      <= en_d;
            sh_q      <= sh_d;
            out_q     <= out_d;
            tmo_err_q <= tmo_err_d;
        end

    always_comb begin
        state_d  = state_q;
        pair_d   = pair_q;
        tmr_load = 1'b0;
        tmr_val  = TMO_LD;
        case (state_q)
            IDLE: if (scan_en) begin
                state_d  = SETTLE;
                pair_d   = IN;
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            SETTLE: if (tmr_zero) state_d = CNV_L;
            CNV_L: begin
                state_d  = WAIT_L;
                tmr_load = 1'b1;
            end
            WAIT_L: if (hit) state_d = CNV_R;
            CNV_R: begin
                state_d  = WAIT_R;
                tmr_load = 1'b1;
            end
            WAIT_R: if (hit) state_d = NEXT;
            NEXT: begin
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
                pair_d   = pair_q == IN ? MID : pair_q == MID ? OUT : IN;
                state_d  = (pair_q != OUT || scan_en) ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sh_d = sh_q;
        if (hit) sh_d[idx] = a2d.cnv_cmplt ? a2d.res : 12'h000;
        // Publish on the edge into NEXT(out) so the set and scan_done appear together.
        out_d         = (hit && rht && pair_q == OUT) ? sh_d : out_q;
        tmo_err_d     = tmo_err_q | (hit && !a2d.cnv_cmplt);
        en_d          = (state_d inside {IDLE, NEXT}) ? 3'b000 : 3'b001 << pair_d;
        a2d.strt_cnv  = state_q inside {CNV_L, CNV_R};
        a2d.chnnl     = (state_q inside {IDLE, SETTLE, NEXT}) ? 3'd0 : pair_chnnl(pair_q, rht);
        scan_done     = state_q == NEXT && pair_q == OUT;
    end

    assign {IR_out_en, IR_mid_en, IR_in_en} = en_q;
    assign lft_in  = out_q[0];
    assign rht_in  = out_q[1];
    assign lft_mid = out_q[2];
    assign rht_mid = out_q[3];
    assign lft_out = out_q[4];
    assign rht_out = out_q[5];
    assign tmo_err = tmo_err_q;
endmodule
